matrix_result_reader: RTL and testbench
=======================================

Name: matrix_result_reader

Overview:
- Downstream of matrix_op_executor. After the executor raises done, this block reads a stored matrix (normally ANS, id 0) from the matrix_storage_manager read port.
- It streams the elements out in row-major order over a valid/ready interface toward the result formatter / UART transmit path.
- It hides the BRAM read latency and absorbs consumer backpressure with a small prefetch FIFO.

Parameters:
- BLOCK_SIZE, 1152: words reserved per matrix slot; slot base = matrix_id*BLOCK_SIZE.
- ADDR_WIDTH, 14: BRAM read address width.
- DATA_WIDTH, 32: element width.
- READ_LATENCY, 1: cycles from bram_read_addr to valid bram_data_out.
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, must be >= READ_LATENCY+1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- matrix_id  in  3  slot to read
- rows  in  8  stored row count
- cols  in  8  stored column count
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last element handshaked
- error  out  1  one-cycle pulse on a rejected request
- bram_read_addr  out  ADDR_WIDTH  storage manager read address
- bram_data_out  in  DATA_WIDTH  storage manager read data
- out_data  out  DATA_WIDTH  element value
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the element
- out_last  out  1  marks the final element
- out_row  out  8  row index of out_data
- out_col  out  8  column index of out_data

Behaviour:
- Reset: interface is one clock; reset is asynchronous and active-high. All outputs 0, state IDLE, FIFO empty, counters 0, in-flight read pipeline cleared.
- State IDLE: on start, latch matrix_id, rows and cols, then go to CHECK. Start while not IDLE is ignored.
- State CHECK (1 cycle): rows==0, cols==0, or rows*cols>BLOCK_SIZE -> error pulse, back to IDLE, no done. Otherwise load addr = matrix_id*BLOCK_SIZE, element count, row 0, col 0, then go to STREAM.
- State STREAM: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH and issued < rows*cols.
  - addr increments by 1 per issued read.
  - Each read carries its (row, col) tag through a READ_LATENCY-deep delay line.
  - col wraps at cols-1 to 0 and row increments; no wrap past rows-1.
  - Returned data plus its tag are pushed into the FIFO exactly READ_LATENCY cycles after issue.
- Once all reads are issued, move to DRAIN. DRAIN ends when the FIFO is empty and nothing is in flight; then go to DONE.
- State DONE: done=1 for exactly one cycle, busy drops the same cycle, return to IDLE.
- Output stream:
  - out_valid = FIFO not empty. out_data, out_row, out_col come from the FIFO head.
  - out_last = head tag is (rows-1, cols-1).
  - Handshake: transfer on out_valid & out_ready.
  - out_data and tags stay stable while out_valid & !out_ready.
  - FIFO push and pop in the same cycle are both allowed; the count is unchanged.
- Throughput: with out_ready held high, one element per cycle. First out_valid appears READ_LATENCY+1 cycles after entering STREAM.
- Backpressure: the FIFO never overflows, because the issue rule reserves a slot for every in-flight read. The FIFO never underflows, because pop requires not empty.
- Arithmetic: rows*cols is computed in 16 bits. The base product is computed at ADDR_WIDTH bits; matrix_id*BLOCK_SIZE plus element count must fit 2^ADDR_WIDTH (true for defaults, since 7*1152+1152 = 9216).
- Reset mid-operation: the stream aborts immediately, with no done and no out_last.

Optional Feature:
- Macro: RESULT_READER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [DATA_WIDTH-1:0].
  - checksum is the wrapping sum of every handshaked element, cleared on accepted start.
  - It is stable and valid in the done cycle and holds until the next accepted start.
- When not defined: no port, no adder logic.

Decomposition:
- Package matrix_result_reader_pkg holds the state enum (IDLE, CHECK, STREAM, DRAIN, DONE) and the packed FIFO entry struct {data, row, col}.
- Sub-module result_stream_fifo: synchronous FIFO, parameters WIDTH and DEPTH.
  - Push/pop/full/empty/count ports.
  - Same asynchronous active-high reset.
  - First-word-fall-through head output.

Test Plan:
- 2x2 slot 0 preloaded [[10,20],[30,40]], out_ready=1 -> outputs 10,20,30,40 on consecutive cycles; tags (0,0),(0,1),(1,0),(1,1); out_last on 40; one done pulse.
- 3x3 slot 3 values 1..9, out_ready toggled 1-0-1-0 -> all 9 in order; data held stable during stalls; bram_read_addr never exceeds 3*1152+8.
- rows=0, cols=5 -> error pulse 2 cycles after start; no out_valid, no done, busy low again.
- rows=40, cols=40 (1600>1152) -> error pulse; the streaming-case start below is accepted afterwards.
- 1x1 matrix value 0xDEADBEEF with out_ready held low 10 cycles -> out_valid high and stable with out_last=1; done only after ready rises. Start asserted during busy is ignored.
- Reset asserted mid-stream of a 4x4 matrix -> all outputs 0 asynchronously; a new 2x2 start afterwards streams correctly. With RESULT_READER_CHECKSUM_EN, the 2x2 case yields checksum 100.

Source files
------------

// File: rtl/matrix_result_reader_pkg.sv
// Shared types for the matrix result reader: FSM state encoding and prefetch FIFO entry layout.
// The element width is fixed here because the FIFO entry struct depends on it.
package matrix_result_reader_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DIM_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DIM_WIDTH-1:0]  row;
        logic [DIM_WIDTH-1:0]  col;
    } fifo_entry_t;

    localparam int ENTRY_WIDTH = $bits(fifo_entry_t);

    function automatic logic tag_is_last(input logic [DIM_WIDTH-1:0] row,
                                         input logic [DIM_WIDTH-1:0] col,
                                         input logic [DIM_WIDTH-1:0] rows,
                                         input logic [DIM_WIDTH-1:0] cols);
        return (row == rows - 8'd1) && (col == cols - 8'd1);
    endfunction

endpackage

// File: rtl/matrix_result_reader_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, used as the prefetch buffer.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/matrix_result_reader.sv
// Reads a stored matrix slot from the storage BRAM and streams it row-major over valid/ready.
// Optional running checksum of delivered elements: define RESULT_READER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start, request fields latched on start
// CHECK  | validate dimensions, load base address and element count
// STREAM | issue BRAM reads while the prefetch FIFO has room
// DRAIN  | all reads issued, wait for FIFO and read pipeline to empty
// DONE   | one-cycle done pulse, then back to IDLE
module matrix_result_reader
    import matrix_result_reader_pkg::*;
#(
    parameter int BLOCK_SIZE   = 1152,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            matrix_id,
    input  logic [7:0]            rows,
    input  logic [7:0]            cols,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] bram_read_addr,
    input  logic [DATA_WIDTH-1:0] bram_data_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [7:0]            out_row,
    output logic [7:0]            out_col
`ifdef RESULT_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q;
    logic [2:0]            mid_q;
    logic [DIM_WIDTH-1:0]  rows_q;
    logic [DIM_WIDTH-1:0]  cols_q;
    logic [15:0]           total_q;
    logic [15:0]           issued_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DIM_WIDTH-1:0]  row_q;
    logic [DIM_WIDTH-1:0]  col_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [CW-1:0]         inflight_q;

    logic                  pipe_vld_q [READ_LATENCY];
    logic [DIM_WIDTH-1:0]  pipe_row_q [READ_LATENCY];
    logic [DIM_WIDTH-1:0]  pipe_col_q [READ_LATENCY];

    logic [15:0]           total_d;
    logic [ADDR_WIDTH-1:0] base_d;
    logic [CW:0]           occupancy;
    logic                  issue_en;
    logic                  last_issue;
    logic                  push_en;
    logic                  pop_en;
    fifo_entry_t           push_entry;
    fifo_entry_t           head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;

    assign total_d   = 16'(rows_q) * 16'(cols_q);
    assign base_d    = ADDR_WIDTH'(mid_q) * ADDR_WIDTH'(BLOCK_SIZE);
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};

    // Every in-flight read already owns a FIFO slot, so the FIFO can never overflow.
    always_comb begin
        issue_en   = 1'b0;
        last_issue = 1'b0;
        if (state_q == STREAM && issued_q != total_q && !fifo_full
            && occupancy < (CW+1)'(FIFO_DEPTH)) begin
            issue_en   = 1'b1;
            last_issue = (issued_q + 16'd1 == total_q);
        end
    end

    assign push_en = pipe_vld_q[READ_LATENCY-1];
    assign pop_en  = out_valid && out_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.data = bram_data_out;
        push_entry.row  = pipe_row_q[READ_LATENCY-1];
        push_entry.col  = pipe_col_q[READ_LATENCY-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mid_q    <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            total_q  <= '0;
            issued_q <= '0;
            addr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mid_q   <= matrix_id;
                        rows_q  <= rows;
                        cols_q  <= cols;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (rows_q == '0 || cols_q == '0 || total_d > 16'(BLOCK_SIZE)) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        addr_q   <= base_d;
                        total_q  <= total_d;
                        issued_q <= '0;
                        row_q    <= '0;
                        col_q    <= '0;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (issue_en) begin
                        issued_q <= issued_q + 16'd1;
                        // Hold the address on the final element so it never leaves the slot.
                        if (!last_issue) addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (col_q == cols_q - 8'd1) begin
                            col_q <= '0;
                            if (row_q != rows_q - 8'd1) row_q <= row_q + 8'd1;
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                        if (last_issue) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && inflight_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_row_q[i] <= '0;
                pipe_col_q[i] <= '0;
            end
            inflight_q <= '0;
        end else begin
            pipe_vld_q[0] <= issue_en;
            pipe_row_q[0] <= row_q;
            pipe_col_q[0] <= col_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_row_q[i] <= pipe_row_q[i-1];
                pipe_col_q[i] <= pipe_col_q[i-1];
            end
            inflight_q <= inflight_q + CW'(issue_en) - CW'(push_en);
        end
    end

    result_stream_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .push_data (push_entry),
        .pop       (pop_en),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head fields are masked while empty so every output reads zero out of reset.
    assign out_valid      = !fifo_empty;
    assign out_data       = out_valid ? head.data : '0;
    assign out_row        = out_valid ? head.row  : '0;
    assign out_col        = out_valid ? head.col  : '0;
    assign out_last       = out_valid && tag_is_last(head.row, head.col, rows_q, cols_q);
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign bram_read_addr = addr_q;

`ifdef RESULT_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (state_q == IDLE && start) begin
            checksum_q <= '0;
        end else if (pop_en) begin
            checksum_q <= checksum_q + head.data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// Self-checking bench for matrix_result_reader: BRAM model, stream monitor and per-scenario tasks.
module tb_matrix_result_reader;

    localparam int BS = 1152;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  matrix_id;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic        busy;
    logic        done;
    logic        error;
    logic [13:0] bram_read_addr;
    logic [31:0] bram_data_out;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
`ifdef RESULT_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:9215];

    logic [31:0] obs_data [$];
    logic [7:0]  obs_row  [$];
    logic [7:0]  obs_col  [$];
    logic        obs_last [$];
    int done_cnt, done_early, stall_viol, stall_cnt, first_valid, last_pop;
    int err_cnt, extra_valid, max_addr;

    matrix_result_reader dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .matrix_id      (matrix_id),
        .rows           (rows),
        .cols           (cols),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .bram_read_addr (bram_read_addr),
        .bram_data_out  (bram_data_out),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .out_row        (out_row),
        .out_col        (out_col)
`ifdef RESULT_READER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Storage manager read port, one cycle of latency.
    always @(posedge clk)
        bram_data_out <= (bram_read_addr < 14'd9216) ? mem[bram_read_addr] : 32'h0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c);
        @(negedge clk);
        start = 1'b1; matrix_id = id; rows = r; cols = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stream monitor: drives out_ready per mode and records what was handshaked.
    // mode 0 ready high, 1 toggling 1-0-1-0, 2 random, 3 low for 10 cycles then high.
    task automatic collect(input int n, input int mode, input int budget);
        logic        pend, r, pl;
        logic [31:0] pd;
        logic [7:0]  pr, pc;
        obs_data.delete(); obs_row.delete(); obs_col.delete(); obs_last.delete();
        done_cnt = 0; done_early = 0; stall_viol = 0; stall_cnt = 0; first_valid = -1;
        last_pop = -1; err_cnt = 0; extra_valid = 0; max_addr = 0; pend = 1'b0;
        pd = '0; pr = '0; pc = '0; pl = 1'b0;
        for (int k = 1; k <= budget && done_cnt == 0; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (obs_data.size() < n) done_early++;
            end
            if (error) err_cnt++;
            if (busy && int'(bram_read_addr) > max_addr) max_addr = int'(bram_read_addr);
            if (pend) begin
                stall_cnt++;
                if (!(out_valid && out_data === pd && out_row === pr && out_col === pc && out_last === pl))
                    stall_viol++;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (k % 2) == 1;
                2:       r = 1'($urandom_range(0, 1));
                default: r = (k > 10);
            endcase
            out_ready = r;
            if (out_valid && first_valid < 0) first_valid = k;
            if (out_valid && r) begin
                obs_data.push_back(out_data); obs_row.push_back(out_row);
                obs_col.push_back(out_col);   obs_last.push_back(out_last);
                last_pop = k;
            end
            pend = out_valid && !r;
            pd = out_data; pr = out_row; pc = out_col; pl = out_last;
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid) extra_valid++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; matrix_id = '0; rows = '0; cols = '0; out_ready = 1'b0;
        for (int i = 0; i < 9216; i++) mem[i] = '0;
        #3;
        n_checks++;
        if ({busy, done, error, out_valid, out_last, out_data, out_row, out_col, bram_read_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b error=%b valid=%b last=%b data=%h addr=%0d, required all 0",
                     busy, done, error, out_valid, out_last, out_data, bram_read_addr);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, error, out_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b error=%b valid=%b, required 0", busy, done, error, out_valid);
        end
    endtask

    task automatic test_2x2();
        int exp_v [4] = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) mem[i] = 32'(exp_v[i]);
        out_ready = 1'b1;
        do_start(3'd0, 8'd2, 8'd2);
        collect(4, 0, 60);
        n_checks++;
        if (obs_data.size() != 4) begin
            n_fail++; $display("FAIL 2x2_count: got %0d elements, required 4", obs_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < 4; i++) begin
            n_checks++;
            if (obs_data[i] !== 32'(exp_v[i]) || obs_row[i] !== 8'(i / 2) || obs_col[i] !== 8'(i % 2)
                || obs_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL 2x2_elem%0d: got data=%0d row=%0d col=%0d last=%b, required data=%0d row=%0d col=%0d last=%b",
                         i, obs_data[i], obs_row[i], obs_col[i], obs_last[i], exp_v[i], i / 2, i % 2, i == 3);
            end
        end
        n_checks++;
        if (first_valid != 3 || last_pop - first_valid != 3) begin
            n_fail++;
            $display("FAIL 2x2_timing: got first_valid=%0d span=%0d, required 3 and 3", first_valid, last_pop - first_valid);
        end
        n_checks++;
        if (done_cnt != 1 || done_early != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL 2x2_done: got pulses=%0d early=%0d busy=%b, required 1 0 0", done_cnt, done_early, busy);
        end
`ifdef RESULT_READER_CHECKSUM_EN
        n_checks++;
        if (checksum !== 32'd100) begin
            n_fail++; $display("FAIL 2x2_checksum: got %0d, required 100", checksum);
        end
`endif
    endtask

    task automatic test_3x3_stall();
        for (int i = 0; i < 9; i++) mem[3 * BS + i] = 32'(i + 1);
        do_start(3'd3, 8'd3, 8'd3);
        collect(9, 1, 100);
        n_checks++;
        if (obs_data.size() != 9) begin
            n_fail++; $display("FAIL 3x3_count: got %0d elements, required 9", obs_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < 9; i++) begin
            n_checks++;
            if (obs_data[i] !== 32'(i + 1) || obs_row[i] !== 8'(i / 3) || obs_col[i] !== 8'(i % 3)
                || obs_last[i] !== (i == 8)) begin
                n_fail++;
                $display("FAIL 3x3_elem%0d: got data=%0d row=%0d col=%0d last=%b, required data=%0d row=%0d col=%0d last=%b",
                         i, obs_data[i], obs_row[i], obs_col[i], obs_last[i], i + 1, i / 3, i % 3, i == 8);
            end
        end
        n_checks++;
        if (stall_viol != 0 || stall_cnt == 0) begin
            n_fail++; $display("FAIL 3x3_stall: got violations=%0d stalls=%0d, required 0 and >0", stall_viol, stall_cnt);
        end
        n_checks++;
        if (max_addr != 3 * BS + 8) begin
            n_fail++; $display("FAIL 3x3_addr: got max addr %0d, required %0d", max_addr, 3 * BS + 8);
        end
        n_checks++;
        if (done_cnt != 1 || done_early != 0) begin
            n_fail++; $display("FAIL 3x3_done: got pulses=%0d early=%0d, required 1 0", done_cnt, done_early);
        end
    endtask

    task automatic test_bad_dims(input logic [7:0] r, input logic [7:0] c);
        int v = 0, d = 0, e = 0;
        out_ready = 1'b1;
        do_start(3'd0, r, c);
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL bad_dims_check_cycle %0dx%0d: got error=%b busy=%b, required 0 1", r, c, error, busy);
        end
        @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bad_dims_error %0dx%0d: got error=%b busy=%b, required 1 0", r, c, error, busy);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) v++;
            if (done) d++;
            if (error) e++;
        end
        n_checks++;
        if (v != 0 || d != 0 || e != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_dims_quiet %0dx%0d: got valid=%0d done=%0d error=%0d busy=%b, required 0 0 0 0", r, c, v, d, e, busy);
        end
    endtask

    task automatic test_1x1_stall();
        mem[5 * BS] = 32'hDEADBEEF;
        mem[2 * BS] = 32'h12345678;
        out_ready = 1'b0;
        do_start(3'd5, 8'd1, 8'd1);
        @(negedge clk);
        start = 1'b1; matrix_id = 3'd2; rows = 8'd1; cols = 8'd1;
        @(negedge clk);
        start = 1'b0;
        collect(1, 3, 60);
        n_checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'hDEADBEEF || obs_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL 1x1_elem: got count=%0d data=%h, required 1 element deadbeef with last",
                     obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'h0);
        end
        n_checks++;
        if (stall_cnt < 8 || stall_viol != 0) begin
            n_fail++; $display("FAIL 1x1_hold: got stalls=%0d violations=%0d, required >=8 and 0", stall_cnt, stall_viol);
        end
        n_checks++;
        if (done_cnt != 1 || done_early != 0 || extra_valid != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL 1x1_ignored_start: got done=%0d early=%0d extra_valid=%0d busy=%b, required 1 0 0 0",
                     done_cnt, done_early, extra_valid, busy);
        end
    endtask

    task automatic test_reset_mid_stream();
        int v = 0, d = 0;
        for (int i = 0; i < 16; i++) mem[BS + i] = $urandom;
        out_ready = 1'b1;
        do_start(3'd1, 8'd4, 8'd4);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, error, out_valid, out_last, out_data, out_row, out_col, bram_read_addr} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b valid=%b last=%b data=%h addr=%0d, required all 0",
                     busy, out_valid, out_last, out_data, bram_read_addr);
        end
`ifdef RESULT_READER_CHECKSUM_EN
        n_checks++;
        if (checksum !== 32'd0) begin
            n_fail++; $display("FAIL midreset_checksum: got %0d, required 0", checksum);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) v++;
            if (done) d++;
        end
        n_checks++;
        if (v != 0 || d != 0) begin
            n_fail++; $display("FAIL midreset_quiet: got valid=%0d done=%0d, required 0 0", v, d);
        end
        test_2x2();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [2:0]  id;
            logic [7:0]  r, c;
            logic [31:0] sum;
            int          n;
            id = 3'($urandom_range(0, 7));
            r  = 8'($urandom_range(1, 8));
            c  = 8'($urandom_range(1, 8));
            n  = int'(r) * int'(c);
            sum = '0;
            for (int i = 0; i < n; i++) begin
                mem[int'(id) * BS + i] = $urandom;
                sum += mem[int'(id) * BS + i];
            end
            do_start(id, r, c);
            collect(n, 2, 20 * n + 40);
            n_checks++;
            if (obs_data.size() != n || done_cnt != 1 || done_early != 0 || stall_viol != 0) begin
                n_fail++;
                $display("FAIL rand%0d_stream %0dx%0d id%0d: got count=%0d done=%0d early=%0d stall_viol=%0d, required %0d 1 0 0",
                         it, r, c, id, obs_data.size(), done_cnt, done_early, stall_viol, n);
            end
            for (int i = 0; i < obs_data.size() && i < n; i++) begin
                n_checks++;
                if (obs_data[i] !== mem[int'(id) * BS + i] || obs_row[i] !== 8'(i / int'(c))
                    || obs_col[i] !== 8'(i % int'(c)) || obs_last[i] !== (i == n - 1)) begin
                    n_fail++;
                    $display("FAIL rand%0d_elem%0d: got data=%h row=%0d col=%0d last=%b, required data=%h row=%0d col=%0d last=%b",
                             it, i, obs_data[i], obs_row[i], obs_col[i], obs_last[i],
                             mem[int'(id) * BS + i], i / int'(c), i % int'(c), i == n - 1);
                end
            end
`ifdef RESULT_READER_CHECKSUM_EN
            n_checks++;
            if (checksum !== sum) begin
                n_fail++; $display("FAIL rand%0d_checksum: got %h, required %h", it, checksum, sum);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_2x2();
        test_3x3_stall();
        test_bad_dims(8'd0, 8'd5);
        test_bad_dims(8'd40, 8'd40);
        test_1x1_stall();
        test_reset_mid_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
